// File: rtl/plic_pkg.sv
// Shared register offsets, gateway state encoding and bus request bundle for plic_lite.
package plic_pkg;

    localparam logic [7:0] PRIO_BASE     = 8'h00;
    localparam logic [7:0] PENDING_OFS   = 8'h80;
    localparam logic [7:0] ENABLE_OFS    = 8'h84;
    localparam logic [7:0] THRESHOLD_OFS = 8'h88;
    localparam logic [7:0] CLAIM_OFS     = 8'h8C;

    typedef enum logic [1:0] {
        GW_IDLE,
        GW_PENDING,
        GW_IN_SERVICE
    } gw_state_e;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [5:0]  word;
        logic [31:0] wdata;
    } bus_req_t;

    function automatic logic [5:0] word_of(input logic [7:0] ofs);
        return ofs[7:2];
    endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source level gateway: latches a request until claimed, then masks the source until completed.
module plic_gateway
    import plic_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic pending,
    output logic in_service
);

    gw_state_e state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GW_IDLE;
        end else begin
            case (state_q)
                GW_IDLE:       if (src)          state_q <= GW_PENDING;
                GW_PENDING:    if (claim_hit)    state_q <= GW_IN_SERVICE;
                // Completion lands in IDLE; a still-high source re-pends on the following edge.
                GW_IN_SERVICE: if (complete_hit) state_q <= GW_IDLE;
                default:                         state_q <= GW_IDLE;
            endcase
        end
    end

    assign pending    = (state_q == GW_PENDING);
    assign in_service = (state_q == GW_IN_SERVICE);

endmodule

// File: rtl/plic_lite.sv
// Lightweight PLIC: per-source gateways, priority/enable/threshold registers, registered arbiter
// and claim/complete handshake driving the core's machine external interrupt.
module plic_lite
    import plic_pkg::*;
#(
    parameter int NUM_SRC = 16,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [7:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic               rvalid_o,
    output logic [31:0]        rdata_o,
    output logic               irq_external_o
);

    localparam int ID_W = 5;

    bus_req_t                       bus;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q;
    logic [NUM_SRC-1:0]             enable_q;
    logic [PRIO_W-1:0]              threshold_q;
    logic [NUM_SRC-1:0]             pending, in_service, claim_hit, complete_hit;
    logic [ID_W-1:0]                best_id_q, best_id_d, claim_id;
    logic [PRIO_W-1:0]              best_prio;
    logic                           claim_rd, complete_wr;
    logic [31:0]                    rdata_d;
    logic                           unused_addr;

    assign bus = '{rd: req_i & ~we_i, wr: req_i & we_i, word: addr_i[7:2], wdata: wdata_i};
    assign unused_addr = ^addr_i[1:0];

    assign claim_rd    = bus.rd && (bus.word == word_of(CLAIM_OFS));
    assign complete_wr = bus.wr && (bus.word == word_of(CLAIM_OFS));

    // A claim only succeeds if the registered winner is still pending and enabled right now.
    always_comb begin
        claim_id = '0;
        for (int s = 0; s < NUM_SRC; s++)
            if (best_id_q == ID_W'(s + 1) && pending[s] && enable_q[s])
                claim_id = best_id_q;
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign claim_hit[s]    = claim_rd && (claim_id == ID_W'(s + 1));
        assign complete_hit[s] = complete_wr && in_service[s] && (bus.wdata == 32'(s + 1));

        plic_gateway u_gw (
            .clk          (clk),
            .rst_n        (rst_n),
            .src          (src_i[s]),
            .claim_hit    (claim_hit[s]),
            .complete_hit (complete_hit[s]),
            .pending      (pending[s]),
            .in_service   (in_service[s])
        );
    end

    // Ascending scan with strict compare keeps the lowest ID on priority ties.
    always_comb begin
        best_id_d = '0;
        best_prio = '0;
        for (int s = 0; s < NUM_SRC; s++)
            if (pending[s] && enable_q[s] && prio_q[s] > threshold_q && prio_q[s] > best_prio) begin
                best_id_d = ID_W'(s + 1);
                best_prio = prio_q[s];
            end
    end

    always_comb begin
        rdata_d = '0;
        if (bus.rd) begin
            for (int s = 0; s < NUM_SRC; s++)
                if (bus.word == word_of(PRIO_BASE) + 6'(s + 1))
                    rdata_d = 32'(prio_q[s]);
            if (bus.word == word_of(PENDING_OFS))   rdata_d = 32'({pending, 1'b0});
            if (bus.word == word_of(ENABLE_OFS))    rdata_d = 32'({enable_q, 1'b0});
            if (bus.word == word_of(THRESHOLD_OFS)) rdata_d = 32'(threshold_q);
            if (bus.word == word_of(CLAIM_OFS))     rdata_d = 32'(claim_id);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q         <= '0;
            enable_q       <= '0;
            threshold_q    <= '0;
            best_id_q      <= '0;
            irq_external_o <= 1'b0;
            rvalid_o       <= 1'b0;
            rdata_o        <= '0;
        end else begin
            if (bus.wr) begin
                for (int s = 0; s < NUM_SRC; s++)
                    if (bus.word == word_of(PRIO_BASE) + 6'(s + 1))
                        prio_q[s] <= bus.wdata[PRIO_W-1:0];
                if (bus.word == word_of(ENABLE_OFS))    enable_q    <= bus.wdata[NUM_SRC:1];
                if (bus.word == word_of(THRESHOLD_OFS)) threshold_q <= bus.wdata[PRIO_W-1:0];
            end
            best_id_q      <= best_id_d;
            irq_external_o <= (best_id_d != '0);
            rvalid_o       <= req_i;
            rdata_o        <= rdata_d;
        end
    end

endmodule

// File: tb/tb_plic_lite.sv
// Directed plus randomized bench for plic_lite against a behavioural interrupt-controller model.
module tb_plic_lite;

    localparam int N  = 16;
    localparam int PW = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] src = '0;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [7:0]   addr = '0;
    logic [31:0]  wdata = '0;
    logic         rvalid;
    logic [31:0]  rdata;
    logic         irq;

    always #5 clk = ~clk;

    plic_lite #(.NUM_SRC(N), .PRIO_W(PW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_i          (src),
        .req_i          (req),
        .we_i           (we),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .rvalid_o       (rvalid),
        .rdata_o        (rdata),
        .irq_external_o (irq)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: ID-indexed state, index 0 unused.
    bit mp  [0:N];
    bit ms  [0:N];
    bit men [0:N];
    int mprio [0:N];
    int mthr;
    int mbest;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int id = 0; id <= N; id++) begin
            mp[id] = 0; ms[id] = 0; men[id] = 0; mprio[id] = 0;
        end
        mthr = 0;
        mbest = 0;
    endtask

    function automatic bit cand(input int id);
        return mp[id] && men[id] && (mprio[id] > mthr);
    endfunction

    // Highest priority first, then the lowest ID holding that priority.
    function automatic int arb();
        int top = 0;
        for (int id = 1; id <= N; id++)
            if (cand(id) && mprio[id] > top) top = mprio[id];
        if (top == 0) return 0;
        for (int id = 1; id <= N; id++)
            if (cand(id) && mprio[id] == top) return id;
        return 0;
    endfunction

    function automatic int claim_val();
        if (mbest != 0 && mp[mbest] && men[mbest]) return mbest;
        return 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int w = int'(a >> 2);
        logic [31:0] v = '0;
        if (w >= 1 && w <= N) v = 32'(mprio[w]);
        else if (w == 32) begin for (int id = 1; id <= N; id++) v[id] = mp[id]; end
        else if (w == 33) begin for (int id = 1; id <= N; id++) v[id] = men[id]; end
        else if (w == 34) v = 32'(mthr);
        else if (w == 35) v = 32'(claim_val());
        return v;
    endfunction

    // One clock: predict from pre-edge state, advance the model, check the DUT after the edge.
    task automatic cycle();
        logic [31:0] rd_exp;
        int cid, nb, w;
        bit ren, wen;
        ren = req && !we;
        wen = req && we;
        w = int'(addr >> 2);
        rd_exp = ren ? model_read(addr) : 32'd0;
        cid = (ren && w == 35) ? claim_val() : 0;
        nb = arb();
        @(posedge clk);
        #1;
        for (int id = 1; id <= N; id++) begin
            if (mp[id]) begin
                if (cid == id) begin mp[id] = 0; ms[id] = 1; end
            end else if (ms[id]) begin
                if (wen && w == 35 && wdata == 32'(id)) ms[id] = 0;
            end else if (src[id-1]) begin
                mp[id] = 1;
            end
        end
        if (wen) begin
            if (w >= 1 && w <= N) mprio[w] = int'(wdata & ((1 << PW) - 1));
            if (w == 33) for (int id = 1; id <= N; id++) men[id] = wdata[id];
            if (w == 34) mthr = int'(wdata & ((1 << PW) - 1));
        end
        mbest = nb;
        check("irq", {31'd0, irq}, {31'd0, mbest != 0});
        check("rvalid", {31'd0, rvalid}, {31'd0, req});
        if (req) check("rdata", rdata, rd_exp);
        req = 0;
        we = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        req = 1; we = 1; addr = a; wdata = d;
        cycle();
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        req = 1; we = 0; addr = a;
        cycle();
        v = rdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [31:0] v;
    int op;

    initial begin
        model_reset();
        #12;
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_rvalid", {31'd0, rvalid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        #5 rst_n = 1;

        // Basic claim
        wr(8'h0C, 2); wr(8'h84, 32'h8); wr(8'h88, 0);
        src[2] = 1;
        cycle();
        check("basic_irq_early", {31'd0, irq}, 32'd0);
        cycle();
        check("basic_irq", {31'd0, irq}, 32'd1);
        rd(8'h8C, v);
        check("basic_claim", v, 32'd3);
        cycle();
        check("basic_irq_drop", {31'd0, irq}, 32'd0);
        rd(8'h80, v);
        check("basic_pend_clear", v, 32'd0);

        // Complete / re-pend while source held high
        wr(8'h8C, 9);
        rd(8'h80, v);
        check("bogus_complete", v, 32'd0);
        wr(8'h8C, 3);
        cycle();
        rd(8'h80, v);
        check("repend", v, 32'h8);
        src[2] = 0;
        idle(2);
        rd(8'h8C, v);
        check("reclaim", v, 32'd3);
        wr(8'h8C, 3);

        // Priority and tie-break
        wr(8'h08, 5); wr(8'h14, 5); wr(8'h1C, 6); wr(8'h84, 32'hA4);
        src[1] = 1; src[4] = 1; src[6] = 1;
        cycle();
        src = '0;
        idle(2);
        rd(8'h8C, v); check("prio_first", v, 32'd7);
        cycle();
        rd(8'h8C, v); check("tie_low_id", v, 32'd2);
        cycle();
        rd(8'h8C, v); check("tie_second", v, 32'd5);
        cycle();
        rd(8'h8C, v); check("prio_empty", v, 32'd0);
        wr(8'h8C, 7); wr(8'h8C, 2); wr(8'h8C, 5);

        // Threshold and enable masking
        wr(8'h10, 3); wr(8'h88, 3); wr(8'h84, 32'h10);
        src[3] = 1;
        cycle();
        src[3] = 0;
        idle(3);
        check("thr_block", {31'd0, irq}, 32'd0);
        wr(8'h88, 2);
        cycle();
        check("thr_pass", {31'd0, irq}, 32'd1);
        wr(8'h84, 0);
        cycle();
        check("en_mask", {31'd0, irq}, 32'd0);
        rd(8'h80, v);
        check("en_keeps_pend", v, 32'h10);

        // Back-to-back claim
        wr(8'h04, 1); wr(8'h88, 0); wr(8'h84, 32'h2);
        src[0] = 1;
        cycle();
        src[0] = 0;
        idle(2);
        rd(8'h8C, v); check("b2b_first", v, 32'd1);
        rd(8'h8C, v); check("b2b_second", v, 32'd0);
        wr(8'h8C, 1);

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 400; i++) begin
            src = N'($urandom & $urandom);
            op = int'($urandom_range(0, 9));
            case (op)
                1: wr(8'($urandom_range(1, N) * 4), $urandom);
                2: wr(8'h84, $urandom);
                3: wr(8'h88, $urandom_range(0, 7));
                4, 5: rd(8'h8C, v);
                6, 7: wr(8'h8C, $urandom_range(0, 19));
                8: rd(8'($urandom_range(0, 255)), v);
                9: wr(8'($urandom_range(17, 63) * 4 + $urandom_range(0, 3)), $urandom);
                default: cycle();
            endcase
        end

        // Reset mid-handshake with ID 3 in service
        src = '0;
        for (int id = 1; id <= N; id++) wr(8'(id * 4), 1);
        for (int id = 1; id <= N; id++) wr(8'h8C, id);
        wr(8'h0C, 7); wr(8'h88, 0); wr(8'h84, 32'h1FFFE);
        src = '1;
        idle(3);
        rd(8'h8C, v);
        check("pre_reset_claim", v, 32'd3);
        cycle();
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        #3 rst_n = 0;
        src = '0;
        #2;
        check("async_irq", {31'd0, irq}, 32'd0);
        check("async_rvalid", {31'd0, rvalid}, 32'd0);
        check("async_rdata", rdata, 32'd0);
        model_reset();
        #1 rst_n = 1;
        for (int id = 1; id <= N; id++) begin
            rd(8'(id * 4), v);
            check("post_reset_prio", v, 32'd0);
        end
        rd(8'h80, v); check("post_reset_pend", v, 32'd0);
        rd(8'h84, v); check("post_reset_en", v, 32'd0);
        rd(8'h88, v); check("post_reset_thr", v, 32'd0);
        rd(8'h8C, v); check("post_reset_claim", v, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plic_lite.md
Name: plic_lite

Overview:
Platform-level interrupt controller that arbitrates up to 31 level-sensitive peripheral interrupt sources onto the core's single machine external interrupt line (irq_external_i of the exception unit). Provides per-source priority, per-source enable, a global threshold and a claim/complete handshake over a simple single-cycle register bus. Sits between the peripherals and the core; software claims the winning ID in its external-interrupt handler and completes it before mret.

Parameters:
NUM_SRC, 16, number of interrupt sources; legal range 1..31; source s (0-based) has ID s+1, ID 0 means "none".
PRIO_W, 3, priority width in bits; priority 0 means never interrupt.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
src_i  input  NUM_SRC  level interrupt requests, already synchronous to clk
req_i  input  1  register access strobe, one cycle per access
we_i  input  1  1 = write, 0 = read
addr_i  input  8  byte address, bits [1:0] ignored
wdata_i  input  32  write data
rvalid_o  output  1  read/write acknowledge, one cycle after req_i
rdata_o  output  32  read data, valid when rvalid_o
irq_external_o  output  1  to core machine external interrupt input

Behaviour:
- Register map: PRIO[id] at id*4 (id 1..NUM_SRC, RW, PRIO_W bits, zero-extended on read); 0x80 PENDING (RO, bit id = pending, bit 0 = 0); 0x84 ENABLE (RW, bit id, bit 0 and bits above NUM_SRC read 0); 0x88 THRESHOLD (RW, PRIO_W bits); 0x8C CLAIM (read) / COMPLETE (write).
- Unmapped reads return 0; writes to unmapped or RO addresses are ignored. Every req_i produces rvalid_o=1 exactly one cycle later; rdata_o is 0 for writes.
- Writes take effect on the clock edge ending the req_i cycle.
- Gateway per source, states IDLE -> PENDING -> IN_SERVICE -> IDLE:
  - IDLE with src_i=1: PENDING next cycle.
  - PENDING: cleared only by a claim returning this ID.
  - IN_SERVICE: src_i ignored; a COMPLETE write with this ID returns the gateway to IDLE. If src_i is still high, it re-pends one cycle later.
  - COMPLETE with an ID not in service, 0, or >NUM_SRC: ignored.
- Arbiter, registered, one-cycle latency: each cycle it selects, among IDs with pending & enable & PRIO > THRESHOLD, the highest PRIO, with the lowest ID winning ties. Result goes to best_id_q; 0 if no candidate.
- irq_external_o = (best_id_q != 0), registered. Latency from src_i rising to irq_external_o is 2 cycles.
- CLAIM read:
  - Returns best_id_q if that ID is still pending & enabled in the current cycle, else 0.
  - A nonzero return clears pending and sets IN_SERVICE on the same edge.
  - Back-to-back claims: the second returns 0 unless a different ID has become best.
- Simultaneous events:
  - A claim of ID a and a new pend of ID b in the same cycle: both take effect.
  - COMPLETE of ID a with src_a high: the pend is not seen in that cycle.
- Changing ENABLE, PRIO or THRESHOLD never alters pending/in-service state. It only affects arbitration from the next cycle.
- Reset, including mid-handshake: all PRIO, ENABLE and THRESHOLD registers are 0, all gateways IDLE, best_id_q=0, irq_external_o=0, rvalid_o=0, rdata_o=0.

Decomposition:
- Package plic_pkg: register offsets (PRIO_BASE, PENDING_OFS, ENABLE_OFS, THRESHOLD_OFS, CLAIM_OFS) and the gateway state enum.
- Sub-module plic_gateway (one instance per source via generate): holds the gateway state. Inputs are src, claim_hit and complete_hit; outputs are pending and in_service.
- The top level holds the registers, the arbiter tree and the bus decode.

Test Plan:
- Basic claim: PRIO[3]=2, ENABLE bit3, THRESHOLD=0, src_i[2]=1 -> irq_external_o=1 two cycles later; CLAIM reads 3; irq drops the next cycle; PENDING bit3=0.
- Priority and tie: PRIO[2]=5, PRIO[5]=5, PRIO[7]=6, all enabled and pending -> claims return 7, then 2, then 5; a fourth claim returns 0.
- Threshold and enable masking: PRIO[4]=3. With THRESHOLD=3, irq stays low; write THRESHOLD=2 -> irq high in 2 cycles; clear ENABLE bit4 -> irq low; PENDING bit4 stays 1.
- Complete/re-pend: claim ID 3 while src high, hold src high -> no re-pend while in service; COMPLETE=3 -> PENDING bit3=1 one cycle later. COMPLETE=9 with ID 9 not in service -> no effect.
- Back-to-back claim: two consecutive CLAIM reads with only ID 1 pending -> returns 1 then 0.
- Reset mid-operation: ID 3 in service with irq high; assert rst_n low asynchronously -> irq_external_o=0 immediately; after release all registers read 0 and CLAIM reads 0.
